// File: rtl/day_plan_pkg.sv
// day_plan_pkg: shared types and constants for the day-plan pixel generator.
package day_plan_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 480;

    // Bound widths of the rectangle coordinates and colour word
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 16;

    // Grid overlay colour, pitch and modulo-counter widths
    localparam logic [CW-1:0] GRID_COLOR   = 16'h8410;
    localparam int            GRID_X_PITCH = 100;
    localparam int            GRID_Y_PITCH = 40;
    localparam int            GXW          = 7;
    localparam int            GYW          = 6;

    typedef struct packed {
        logic          en;
        logic [XW-1:0] x0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y0;
        logic [YW-1:0] y1;
        logic [CW-1:0] color;
    } rect_t;

    typedef enum logic {
        ACTIVE = 1'b0,
        DONE   = 1'b1
    } gen_state_t;

endpackage

// File: rtl/rect_hit_test.sv
// rect_hit_test: combinational priority hit test of one pixel against all
// rectangle slots; the lowest-index enabled slot containing the pixel wins.
module rect_hit_test
    import day_plan_pkg::*;
#(
    parameter int NUM_RECTS = 8
) (
    input  logic [XW-1:0]              i_x,
    input  logic [YW-1:0]              i_y,
    input  rect_t [NUM_RECTS-1:0]      i_rects,
    output logic                       o_hit,
    output logic [CW-1:0]              o_color
);

    // Scan from the highest slot down so the lowest matching index is the last writer.
    // Inverted bounds (x0>x1 or y0>y1) can never satisfy both compares.
    always_comb begin
        o_hit   = 1'b0;
        o_color = '0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (i_rects[i].en &&
                (i_rects[i].x0 <= i_x) && (i_x <= i_rects[i].x1) &&
                (i_rects[i].y0 <= i_y) && (i_y <= i_rects[i].y1)) begin
                o_hit   = 1'b1;
                o_color = i_rects[i].color;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: row-major raster scan emitting one RGB565 word per pixel,
// each pixel held for two accepted beats. Rectangles are double-banked so a
// frame never tears. Optional grid overlay: define GRID_OVERLAY_EN.
module pixel_stream_gen
    import day_plan_pkg::*;
#(
    parameter int            H_ACTIVE      = H_ACTIVE_DEF,
    parameter int            V_ACTIVE      = V_ACTIVE_DEF,
    parameter int            NUM_RECTS     = 8,
    parameter logic [CW-1:0] BG_COLOR      = 16'h0000,
    parameter int            BEATS_PER_PIX = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ready,
    input  logic                          frame_sync,
    output logic                          valid,
    output logic [CW-1:0]                 dataOut,
    input  logic                          rect_we,
    input  logic [$clog2(NUM_RECTS)-1:0]  rect_idx,
    input  logic                          rect_en,
    input  logic [XW-1:0]                 rect_x0,
    input  logic [XW-1:0]                 rect_x1,
    input  logic [YW-1:0]                 rect_y0,
    input  logic [YW-1:0]                 rect_y1,
    input  logic [CW-1:0]                 rect_color,
    output logic                          frame_err
);

    localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);
    localparam logic          LAST_PHASE = 1'(BEATS_PER_PIX - 1);
`ifdef GRID_OVERLAY_EN
    localparam logic [GXW-1:0] GX_LAST   = GXW'(GRID_X_PITCH - 1);
    localparam logic [GYW-1:0] GY_LAST   = GYW'(GRID_Y_PITCH - 1);
    // Pixel (0,0) sits on both grid lines
    localparam logic [CW-1:0]  RST_COLOR = GRID_COLOR;
`else
    localparam logic [CW-1:0]  RST_COLOR = BG_COLOR;
`endif

    gen_state_t            r_state, w_state_nxt;
    logic [XW-1:0]         r_x, w_x_nxt;
    logic [YW-1:0]         r_y, w_y_nxt;
    logic                  r_phase, w_phase_nxt;
    logic                  r_valid, w_valid_nxt;
    logic [CW-1:0]         r_data;
    logic                  r_err;
    rect_t [NUM_RECTS-1:0] r_shadow, r_active, w_bank;
    rect_t                 w_wr_rect;
    logic                  w_acc, w_adv, w_last, w_ld, w_copy, w_err_set;
    logic                  w_hit;
    logic [CW-1:0]         w_hit_color, w_color;
`ifdef GRID_OVERLAY_EN
    logic [GXW-1:0]        r_xm, w_xm_nxt;
    logic [GYW-1:0]        r_ym, w_ym_nxt;
`endif

    assign w_acc  = r_valid && ready && (r_state == ACTIVE);
    assign w_adv  = w_acc && (r_phase == LAST_PHASE);
    assign w_last = w_adv && (r_x == X_LAST) && (r_y == Y_LAST);

    assign w_wr_rect = '{en: rect_en, x0: rect_x0, x1: rect_x1,
                         y0: rect_y0, y1: rect_y1, color: rect_color};

    // At restart the (0,0) colour must come from the bank being loaded
    assign w_bank = w_copy ? r_shadow : r_active;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ACTIVE;
        else     r_state <= w_state_nxt;
    end

    // Next state: a frame_sync on the final acceptance restarts instead of stopping
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACTIVE:  if (!frame_sync && w_last) w_state_nxt = DONE;
            DONE:    if (frame_sync) w_state_nxt = ACTIVE;
            default: w_state_nxt = ACTIVE;
        endcase
    end

    // Counter/output control: restart beats everything, else step on acceptance
    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_phase_nxt = r_phase;
        w_valid_nxt = r_valid;
        w_ld        = 1'b0;
        w_copy      = 1'b0;
        w_err_set   = 1'b0;
        if (frame_sync) begin
            w_copy      = 1'b1;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_phase_nxt = 1'b0;
            w_valid_nxt = 1'b1;
            w_ld        = 1'b1;
            w_err_set   = (r_state == ACTIVE) && !w_last;
        end else if (w_adv) begin
            w_phase_nxt = 1'b0;
            w_ld        = 1'b1;
            if (r_x == X_LAST) begin
                w_x_nxt = '0;
                if (r_y == Y_LAST) begin
                    w_y_nxt     = '0;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_y_nxt = r_y + 1'b1;
                end
            end else begin
                w_x_nxt = r_x + 1'b1;
            end
        end else if (w_acc) begin
            w_phase_nxt = ~r_phase;
        end
    end

`ifdef GRID_OVERLAY_EN
    // Grid modulo counters track x/y so no divider is needed
    always_comb begin
        w_xm_nxt = r_xm;
        w_ym_nxt = r_ym;
        if (frame_sync) begin
            w_xm_nxt = '0;
            w_ym_nxt = '0;
        end else if (w_adv) begin
            if (r_x == X_LAST) begin
                w_xm_nxt = '0;
                if (r_y == Y_LAST)     w_ym_nxt = '0;
                else if (r_ym == GY_LAST) w_ym_nxt = '0;
                else                   w_ym_nxt = r_ym + 1'b1;
            end else begin
                w_xm_nxt = (r_xm == GX_LAST) ? '0 : r_xm + 1'b1;
            end
        end
    end

    // Grid modulo registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xm <= '0;
            r_ym <= '0;
        end else begin
            r_xm <= w_xm_nxt;
            r_ym <= w_ym_nxt;
        end
    end
`endif

    rect_hit_test #(.NUM_RECTS(NUM_RECTS)) u_hit (
        .i_x     (w_x_nxt),
        .i_y     (w_y_nxt),
        .i_rects (w_bank),
        .o_hit   (w_hit),
        .o_color (w_hit_color)
    );

    // Colour of the next pixel: rectangles over grid over background
    always_comb begin
        w_color = BG_COLOR;
`ifdef GRID_OVERLAY_EN
        if ((w_xm_nxt == '0) || (w_ym_nxt == '0)) w_color = GRID_COLOR;
`endif
        if (w_hit) w_color = w_hit_color;
    end

    // Datapath registers; dataOut only reloads when the pixel changes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
            r_valid <= 1'b1;
            r_data  <= RST_COLOR;
            r_err   <= 1'b0;
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_phase <= w_phase_nxt;
            r_valid <= w_valid_nxt;
            if (w_ld)      r_data <= w_color;
            if (w_err_set) r_err  <= 1'b1;
        end
    end

    // Banks: a write coinciding with the copy lands in shadow after the copy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (w_copy)  r_active           <= r_shadow;
            if (rect_we) r_shadow[rect_idx] <= w_wr_rect;
        end
    end

    assign valid     = r_valid;
    assign dataOut   = r_data;
    assign frame_err = r_err;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// tb_pixel_stream_gen: scoreboard bench on a reduced 40x12 raster.
module tb_pixel_stream_gen;

    localparam int H  = 40;
    localparam int V  = 12;
    localparam int NR = 8;
    localparam int FB = 2 * H * V;

    logic        clk = 1'b0;
    logic        rst, ready, frame_sync, valid, rect_we, rect_en, frame_err;
    logic [15:0] dataOut, rect_color;
    logic [2:0]  rect_idx;
    logic [9:0]  rect_x0, rect_x1;
    logic [8:0]  rect_y0, rect_y1;

    always #5 clk = ~clk;

    pixel_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .NUM_RECTS(NR)) dut (
        .clk(clk), .rst(rst), .ready(ready), .frame_sync(frame_sync),
        .valid(valid), .dataOut(dataOut), .rect_we(rect_we), .rect_idx(rect_idx),
        .rect_en(rect_en), .rect_x0(rect_x0), .rect_x1(rect_x1),
        .rect_y0(rect_y0), .rect_y1(rect_y1), .rect_color(rect_color),
        .frame_err(frame_err)
    );

    typedef struct {
        bit          en;
        int          x0, x1, y0, y1;
        logic [15:0] c;
    } mrect_t;

    mrect_t      sh[NR], act[NR];
    logic [15:0] exp_q[$];
    logic [15:0] cap[FB];
    int          total_beats = 0;
    int          base = 0;
    int          n_cmp = 0, n_err = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic mrect_t mk(bit en, int x0, int x1, int y0, int y1, logic [15:0] c);
        mrect_t r;
        r.en = en; r.x0 = x0; r.x1 = x1; r.y0 = y0; r.y1 = y1; r.c = c;
        return r;
    endfunction

    function automatic logic [15:0] mcolor(int x, int y);
        for (int i = 0; i < NR; i++)
            if (act[i].en && act[i].x0 <= x && x <= act[i].x1 && act[i].y0 <= y && y <= act[i].y1)
                return act[i].c;
        return 16'h0000;
    endfunction

    task automatic push_frame();
        exp_q.delete();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                exp_q.push_back(mcolor(x, y));
                exp_q.push_back(mcolor(x, y));
            end
        base = total_beats;
    endtask

    task automatic drive_rect(int idx, mrect_t r);
        rect_idx   = 3'(idx);
        rect_en    = r.en;
        rect_x0    = 10'(r.x0);
        rect_x1    = 10'(r.x1);
        rect_y0    = 9'(r.y0);
        rect_y1    = 9'(r.y1);
        rect_color = r.c;
    endtask

    task automatic wr_rect(int idx, mrect_t r);
        @(posedge clk); #1;
        drive_rect(idx, r);
        rect_we = 1'b1;
        sh[idx] = r;
        @(posedge clk); #1;
        rect_we = 1'b0;
    endtask

    // Pulse frame_sync from DONE, optionally with a same-cycle shadow write
    task automatic sync_frame(bit with_wr, int idx, mrect_t r);
        @(posedge clk); #1;
        frame_sync = 1'b1;
        for (int i = 0; i < NR; i++) act[i] = sh[i];
        if (with_wr) begin
            drive_rect(idx, r);
            rect_we = 1'b1;
            sh[idx] = r;
        end
        @(posedge clk); #1;
        frame_sync = 1'b0;
        rect_we    = 1'b0;
        push_frame();
    endtask

    // Wait for the scoreboard to drain, then confirm DONE behaviour
    task automatic wait_done(string name, bit rnd_ready, bit do_wr);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk); #1;
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
            if (do_wr && n == 200) begin
                drive_rect(0, mk(1, 10, 19, 5, 6, 16'h07FF));
                rect_we = 1'b1;
                sh[0].c = 16'h07FF;
            end else begin
                rect_we = 1'b0;
            end
            n++;
        end
        rect_we = 1'b0;
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got %0d beats left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        ready = 1'b1;
        check({name, "_beats"}, 32'(total_beats - base), 32'(FB));
        check({name, "_done_valid"}, 32'(valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_hold"}, 32'(valid), 32'd0);
    endtask

    // Monitor: every accepted beat is popped and compared
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (total_beats - base < FB) cap[total_beats - base] = dataOut;
            total_beats++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_beat: got %h, expected no beat", dataOut);
            end else begin
                check("beat", 32'(dataOut), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; ready = 1'b0; frame_sync = 1'b0; rect_we = 1'b0;
        drive_rect(0, mk(0, 0, 0, 0, 0, 16'h0000));
        for (int i = 0; i < NR; i++) begin
            sh[i] = mk(0, 0, 0, 0, 0, 16'h0000);
            act[i] = sh[i];
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 32'(valid), 32'd1);
        check("rst_data", 32'(dataOut), 32'h0000);
        check("rst_err", 32'(frame_err), 32'd0);

        // Frame 0: empty bank, continuous ready
        push_frame();
        ready = 1'b1;
        wait_done("f0", 0, 0);

        // Frame 1: configured rectangles incl. overlap, disabled and inverted slots
        wr_rect(0, mk(1, 10, 19, 5, 6, 16'hF800));
        wr_rect(1, mk(0, 0, 39, 0, 11, 16'hFFFF));
        wr_rect(2, mk(1, 20, 5, 0, 11, 16'hFFFF));
        wr_rect(3, mk(1, 8, 12, 5, 5, 16'h001F));
        wr_rect(4, mk(1, 30, 35, 9, 11, 16'h07E0));
        wr_rect(5, mk(1, 0, 39, 9, 2, 16'hFFFF));
        wr_rect(6, mk(1, 32, 38, 10, 11, 16'h001F));
        sync_frame(0, 0, mk(0, 0, 0, 0, 0, 0));
        check("f1_err", 32'(frame_err), 32'd0);
        wait_done("f1", 0, 0);
        check("f1_px10_5a", 32'(cap[420]), 32'hF800);
        check("f1_px10_5b", 32'(cap[421]), 32'hF800);
        check("f1_px20_5", 32'(cap[440]), 32'h0000);
        check("f1_px8_5", 32'(cap[416]), 32'h001F);
        check("f1_px33_10", 32'(cap[866]), 32'h07E0);
        check("f1_px37_10", 32'(cap[874]), 32'h001F);
        check("f1_px0_0", 32'(cap[0]), 32'h0000);

        // Frame 2: random ready, slot 0 recoloured mid-frame (not visible yet)
        sync_frame(0, 0, mk(0, 0, 0, 0, 0, 0));
        wait_done("f2", 1, 1);
        check("f2_old_color", 32'(cap[420]), 32'hF800);

        // Frame 3: new colour visible; slot 7 written in the copy cycle
        sync_frame(1, 7, mk(1, 0, 0, 0, 0, 16'hFFFF));
        n = 0;
        while (exp_q.size() != 1 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("f3_new_color", 32'(cap[420]), 32'h07FF);
        check("f3_late_write", 32'(cap[0]), 32'h0000);
        // frame_sync coincides with the final acceptance: no error
        frame_sync = 1'b1;
        for (int i = 0; i < NR; i++) act[i] = sh[i];
        @(posedge clk); #1;
        frame_sync = 1'b0;
        push_frame();
        check("f4_err_final_beat", 32'(frame_err), 32'd0);

        // Frame 4: frame_sync injected at beat 100
        n = 0;
        while (total_beats - base < 100 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        frame_sync = 1'b1;
        for (int i = 0; i < NR; i++) act[i] = sh[i];
        @(posedge clk); #1;
        frame_sync = 1'b0;
        push_frame();
        check("f5_err_set", 32'(frame_err), 32'd1);
        wait_done("f5", 0, 0);
        check("f5_px0_0", 32'(cap[0]), 32'hFFFF);
        check("f5_err_sticky", 32'(frame_err), 32'd1);

        // Reset mid-frame clears error and both banks
        sync_frame(0, 0, mk(0, 0, 0, 0, 0, 0));
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            sh[i] = mk(0, 0, 0, 0, 0, 16'h0000);
            act[i] = sh[i];
        end
        check("rst2_valid", 32'(valid), 32'd1);
        check("rst2_data", 32'(dataOut), 32'h0000);
        check("rst2_err", 32'(frame_err), 32'd0);
        push_frame();
        wait_done("f6", 0, 0);
        check("f6_px0_0", 32'(cap[0]), 32'h0000);
        check("f6_px10_5", 32'(cap[420]), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_stream_gen.md
Name: pixel_stream_gen

Overview:
- Upstream pixel source for LCDController during the drawRec phase.
- Scans an 800x480 raster in row-major order and emits one RGB565 word per pixel on a valid/ready stream.
- Each pixel is held for two accepted beats to match the controller's wr low/high toggle.
- Colour: up to NUM_RECTS configurable filled rectangles (day-plan blocks) over a background; restarts on the controller's frame_sync.

Parameters:
- H_ACTIVE, 800, pixels per line
- V_ACTIVE, 480, lines per frame
- NUM_RECTS, 8, rectangle slots (power of 2)
- BG_COLOR, 16'h0000, RGB565 background
- BEATS_PER_PIX, 2, accepted beats per pixel (fixed at 2; other values are unsupported)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ready  in  1  controller accepts a beat (high in pixel phase only)
- frame_sync  in  1  one-cycle pulse at the end of the controller's frame
- valid  out  1  dataOut carries a pixel beat
- dataOut  out  16  RGB565 pixel
- rect_we  in  1  write one rectangle slot into the shadow bank
- rect_idx  in  $clog2(NUM_RECTS)  slot index
- rect_en  in  1  slot enable
- rect_x0, rect_x1  in  10 each  inclusive column bounds
- rect_y0, rect_y1  in  9 each  inclusive row bounds
- rect_color  in  16  slot colour
- frame_err  out  1  sticky: frame_sync arrived mid-frame

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset values:
  - state=ACTIVE, x=0, y=0, phase=0, valid=1, dataOut=BG_COLOR, frame_err=0.
  - Shadow and active banks: all rect_en=0.
- A beat is accepted when valid&&ready. Each acceptance toggles phase.
- On the phase=1 acceptance, the pixel advances:
  - x+1.
  - At x=H_ACTIVE-1: x=0, y+1.
- dataOut and valid are registered.
  - dataOut for the next pixel is computed from next (x,y) and registered in the same cycle the pixel advances.
  - dataOut is stable across both beats of a pixel. Zero-bubble: back-to-back ready gives one beat per cycle.
- ready low: hold x, y, phase, dataOut and valid. No beat is lost.
- Colour rule:
  - The lowest-index enabled slot with x0<=x<=x1 and y0<=y<=y1 wins.
  - With no hit, output BG_COLOR.
  - A slot with x0>x1 or y0>y1 never hits.
  - Comparisons are unsigned on the bound widths.
- States:
  - ACTIVE: stream pixels. After the phase=1 acceptance of pixel (H_ACTIVE-1, V_ACTIVE-1) -> DONE with valid=0. This is 768000 beats per frame.
  - DONE: valid=0; ignore ready. On frame_sync:
    - copy the shadow bank to the active bank;
    - x=y=phase=0;
    - dataOut=colour(0,0) computed from the newly loaded bank;
    - valid=1;
    - -> ACTIVE.
  - The controller's frame_sync coincides with its final beat count, so frame_sync normally lands in DONE or in the cycle DONE is entered. A frame_sync in the same cycle as the final acceptance is treated as if it arrived in DONE.
  - frame_sync in ACTIVE (not the final-beat cycle):
    - set frame_err;
    - perform the DONE restart (bank copy, counters to 0) and stay in ACTIVE.
    - frame_err clears only on rst.
- Configuration:
  - rect_we writes the shadow bank only. The active bank changes only at frame restart, so there is no mid-frame tearing.
  - A write in the same cycle as the bank copy is applied to the shadow bank after the copy; it becomes visible next frame.
- Reset mid-frame returns to pixel (0,0) in ACTIVE and clears both banks.

Optional Feature:
- Macro GRID_OVERLAY_EN.
- Defined:
  - Rows where y mod 40 == 0 and columns where x mod 100 == 0 are drawn in grid colour 16'h8410.
  - Grid priority: above background, below all rectangles.
  - Grid position comes from separate x/y modulo counters advancing with x/y (no divider).
- Undefined:
  - No grid logic is present.
  - The colour rule is rectangles over BG_COLOR only.

Decomposition:
- Package day_plan_pkg:
  - rect_t struct (en, x0, x1, y0, y1, color);
  - H_ACTIVE/V_ACTIVE defaults;
  - gen_state_t enum {ACTIVE, DONE};
  - GRID_COLOR and grid pitch constants.
- Sub-module rect_hit_test: combinational.
  - Inputs: x, y and the active rect_t array.
  - Outputs: hit and the winning colour (priority encoder).
- pixel_stream_gen holds the counters, FSM, banks and output registers.

Test Plan:
- Reset, ready=1 continuous, no rects: valid=1; dataOut=16'h0000 for exactly 768000 beats, then valid=0 until frame_sync.
- Rect 0 = (10..19, 5..6, 16'hF800, en) and frame_sync: pixel (10,5) appears at beats 2*(5*800+10) and +1 as 16'hF800; pixel (20,5) is 16'h0000.
- Overlapping slots 0 (16'h07E0) and 3 (16'h001F) covering (100,100): output 16'h07E0.
- ready toggled randomly (roughly 50%) in a frame with rects configured: every pixel appears for exactly 2 accepted beats; the sequence matches a reference model; the total is 768000 beats.
- rect_we mid-frame changing slot 0 colour: the current frame keeps the old colour; the frame after frame_sync shows the new colour.
- frame_sync injected at beat 1000: frame_err=1; the next accepted beat is pixel (0,0) phase 0.
